// File: rtl/sincos_quadrant_seq_if.sv
// Request/response bundle for the sin/cos quadrant sequencer.
// The master side issues angles and consumes results. The slave side is the sequencer.
interface sincos_quadrant_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] angle;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sin_out;
  logic [15:0] cos_out;

  modport master (
    output in_valid,
    output angle,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sin_out,
    input  cos_out
  );

  modport slave (
    input  in_valid,
    input  angle,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sin_out,
    output cos_out
  );
endinterface

// File: rtl/sincos_quadrant_seq.sv
// sin/cos sequencer in front of a quarter-wave sine table.
// Each accepted angle makes two serial table lookups: the first for sin, the second for cos (angle + 90 deg).
// Every lookup angle is folded into the first quadrant, and the result gets a mirror and sign correction.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | ready for a new angle (in_ready=1)
// SIN_WAIT | sin table address driven, waiting ROM_LAT clocks
// SIN_CAP  | table data valid: capture signed sin, drive cos addr
// COS_WAIT | cos table address driven, waiting ROM_LAT clocks
// COS_CAP  | table data valid: capture signed cos, raise out_valid
// HOLD     | result presented until the consumer takes it
module sincos_quadrant_seq #(
  parameter int N       = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  sincos_quadrant_seq_if.slave bus,
  output logic [N-1:0]         rom_addr,
  input  logic [15:0]          rom_data
);

  localparam int             CW        = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CW-1:0]  WAIT_LOAD = CW'(ROM_LAT - 1);
  // 2^N at N+1 bits: the mirror point of the quarter wave.
  localparam logic [N:0]     QUARTER   = {1'b1, {N{1'b0}}};
  // +90 deg expressed on the quadrant+index bits only; the lower bits never carry into them.
  localparam logic [N+1:0]   COS_SHIFT = {2'b01, {N{1'b0}}};
  localparam logic [15:0]    FULL_SCALE = 16'h7FFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SIN_WAIT = 3'd1,
    SIN_CAP  = 3'd2,
    COS_WAIT = 3'd3,
    COS_CAP  = 3'd4,
    HOLD     = 3'd5
  } state_t;

  typedef struct packed {
    logic [N-1:0] addr;
    logic         ovr;   // exact 90/270 deg: the table is not read, and full scale is used
    logic         neg;
  } fold_t;

  // Fold a quadrant+index into a table address plus mirror/sign flags.
  function automatic fold_t fold(input logic [N+1:0] top);
    fold_t r;
    r.neg  = top[N+1];
    r.ovr  = 1'b0;
    r.addr = top[N-1:0];
    if (top[N]) begin
      if (top[N-1:0] == '0) begin
        // 2^N - 0 would fall outside the table, so park the address at 0 instead.
        r.addr = '0;
        r.ovr  = 1'b1;
      end else begin
        r.addr = N'(QUARTER - {1'b0, top[N-1:0]});
      end
    end
    return r;
  endfunction

  // Magnitude never exceeds 0x7FFF, so the two's complement cannot overflow.
  function automatic logic [15:0] apply_sign(input logic ovr, input logic neg,
                                             input logic [15:0] data);
    logic [15:0] mag;
    mag = ovr ? FULL_SCALE : data;
    return neg ? (~mag + 16'd1) : mag;
  endfunction

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          cur_ovr;
  logic          cur_neg;
  fold_t         cos_fold;

  logic [N+1:0]  angle_top;
  fold_t         sin_f;
  fold_t         cos_f;
  logic          unused_angle_lsbs;

  // Only the quadrant and table-index bits of the angle take part in the lookup.
  assign angle_top         = bus.angle[15:14-N];
  assign unused_angle_lsbs = ^bus.angle[13-N:0];
  assign sin_f             = fold(angle_top);
  assign cos_f             = fold(angle_top + COS_SHIFT);

  // Lookup sequencer: accept, two serial table reads, hold result for handshake.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.sin_out   <= '0;
      bus.cos_out   <= '0;
      rom_addr      <= '0;
      wait_cnt      <= '0;
      cur_ovr       <= 1'b0;
      cur_neg       <= 1'b0;
      cos_fold      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            rom_addr     <= sin_f.addr;
            cur_ovr      <= sin_f.ovr;
            cur_neg      <= sin_f.neg;
            cos_fold     <= cos_f;
            wait_cnt     <= WAIT_LOAD;
            bus.in_ready <= 1'b0;
            state        <= SIN_WAIT;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        SIN_WAIT: begin
          if (wait_cnt == '0) state <= SIN_CAP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        SIN_CAP: begin
          bus.sin_out <= apply_sign(cur_ovr, cur_neg, rom_data);
          rom_addr    <= cos_fold.addr;
          cur_ovr     <= cos_fold.ovr;
          cur_neg     <= cos_fold.neg;
          wait_cnt    <= WAIT_LOAD;
          state       <= COS_WAIT;
        end
        COS_WAIT: begin
          if (wait_cnt == '0) state <= COS_CAP;
          else                wait_cnt <= wait_cnt - 1'b1;
        end
        COS_CAP: begin
          bus.cos_out   <= apply_sign(cur_ovr, cur_neg, rom_data);
          bus.out_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_quadrant_seq.sv
// Bench for sincos_quadrant_seq. It uses a registered table model with T[k] = k*201, N=4 and ROM_LAT=1.
module tb_sincos_quadrant_seq;

  logic        sys_clk;
  logic        rst_n;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {
    logic [15:0] s;
    logic [15:0] c;
  } exp_t;
  exp_t sb_q[$];

  sincos_quadrant_seq_if bus ();

  sincos_quadrant_seq #(.N(4), .ROM_LAT(1)) dut (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_data (rom_data)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // Registered table read: data follows the address by one clock.
  always @(posedge sys_clk) rom_data <= 16'(rom_addr) * 16'd201;

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: quarter-wave table folding, computed from the angle in integer arithmetic.
  function automatic logic [15:0] model(input logic [15:0] a);
    int q, idx, k, mag;
    q   = int'(a[15:14]);
    idx = int'(a[13:10]);
    k   = (q % 2 == 1) ? 16 - idx : idx;
    mag = (k == 16) ? 32767 : k * 201;
    return (q >= 2) ? 16'(-mag) : 16'(mag);
  endfunction

  task automatic issue(input logic [15:0] a, input bit keep, output int acc);
    int n;
    exp_t e;
    @(negedge sys_clk);
    bus.in_valid = 1'b1;
    bus.angle    = a;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_timeout angle=%h in_ready=%b want 1", a, bus.in_ready);
    end
    e.s = model(a);
    e.c = model(a + 16'h4000);
    sb_q.push_back(e);
    @(posedge sys_clk);
    #1;
    acc = cyc;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, output int seen);
    int n;
    exp_t e;
    @(negedge sys_clk);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    seen = cyc;
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL %s out_valid_timeout got %b want 1", name, bus.out_valid);
    end
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected_result sb_size=0 want >0", name);
    end else begin
      e = sb_q.pop_front();
      total++;
      if (bus.sin_out !== e.s) begin
        bad++;
        $display("FAIL %s sin got %h want %h", name, bus.sin_out, e.s);
      end
      total++;
      if (bus.cos_out !== e.c) begin
        bad++;
        $display("FAIL %s cos got %h want %h", name, bus.cos_out, e.c);
      end
    end
    if (bus.out_ready === 1'b1) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.angle     = 16'h0;
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got in_ready=%b out_valid=%b want 0 0", bus.in_ready, bus.out_valid);
    end
    total++;
    if (rom_addr !== 4'h0) begin
      bad++;
      $display("FAIL reset_rom_addr got %h want 0", rom_addr);
    end
    total++;
    if ({bus.sin_out, bus.cos_out} !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got sin=%h cos=%h want 0 0", bus.sin_out, bus.cos_out);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL release_before_edge in_ready got %b want 0", bus.in_ready);
    end
    @(posedge sys_clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL release_first_edge in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic;
    int acc, seen;
    issue(16'h1000, 1'b0, acc);
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_in_ready_cleared got %b want 0", bus.in_ready);
    end
    collect("basic", seen);
    total++;
    if (seen - acc != 4) begin
      bad++;
      $display("FAIL basic_latency got %0d want 4", seen - acc);
    end
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'h0324, 16'h096C}) begin
      bad++;
      $display("FAIL basic_const got sin=%h cos=%h want 0324 096c", bus.sin_out, bus.cos_out);
    end
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL basic_handshake got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_mirror;
    int acc, seen;
    issue(16'h0000, 1'b0, acc);
    collect("mirror_0000", seen);
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'h0000, 16'h7FFF}) begin
      bad++;
      $display("FAIL mirror_0000_const got sin=%h cos=%h want 0000 7fff", bus.sin_out, bus.cos_out);
    end
    issue(16'hC000, 1'b0, acc);
    collect("mirror_c000", seen);
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'h8001, 16'h0000}) begin
      bad++;
      $display("FAIL mirror_c000_const got sin=%h cos=%h want 8001 0000", bus.sin_out, bus.cos_out);
    end
  endtask

  task automatic test_sign_wrap;
    int acc, seen;
    issue(16'h9000, 1'b0, acc);
    collect("sign_9000", seen);
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'hFCDC, 16'hF694}) begin
      bad++;
      $display("FAIL sign_9000_const got sin=%h cos=%h want fcdc f694", bus.sin_out, bus.cos_out);
    end
    issue(16'hF000, 1'b0, acc);
    collect("wrap_f000", seen);
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'hFCDC, 16'h096C}) begin
      bad++;
      $display("FAIL wrap_f000_const got sin=%h cos=%h want fcdc 096c", bus.sin_out, bus.cos_out);
    end
  endtask

  task automatic test_backpressure;
    int acc, seen;
    logic [15:0] s0, c0;
    bus.out_ready = 1'b0;
    issue(16'h5000, 1'b0, acc);
    collect("bp", seen);
    s0 = bus.sin_out;
    c0 = bus.cos_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.sin_out, bus.cos_out} !== {2'b10, s0, c0}) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got v=%b r=%b sin=%h cos=%h want 1 0 %h %h",
                 i, bus.out_valid, bus.in_ready, bus.sin_out, bus.cos_out, s0, c0);
      end
      bus.in_valid = (i % 2 == 0);
      bus.angle    = 16'h2000 + 16'(i * 16'h0400);
    end
    @(negedge sys_clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL bp_ignored_pulse cycle=%0d out_valid got %b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc1, acc2, seen;
    int n;
    exp_t e;
    bus.out_ready = 1'b1;
    issue(16'h1000, 1'b1, acc1);
    bus.angle = 16'h5000;
    e.s = model(16'h5000);
    e.c = model(16'h9000);
    sb_q.push_back(e);
    collect("b2b_first", seen);
    n = 0;
    @(negedge sys_clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    #1;
    acc2 = cyc;
    bus.in_valid = 1'b0;
    total++;
    if (acc2 - acc1 != 6) begin
      bad++;
      $display("FAIL b2b_spacing got %0d want 6", acc2 - acc1);
    end
    collect("b2b_second", seen);
    total++;
    if ({bus.sin_out, bus.cos_out} !== {16'h096C, 16'hFCDC}) begin
      bad++;
      $display("FAIL b2b_second_const got sin=%h cos=%h want 096c fcdc", bus.sin_out, bus.cos_out);
    end
  endtask

  task automatic test_random;
    int acc, seen;
    logic [15:0] a;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom);
      issue(a, 1'b0, acc);
      collect("random", seen);
      total++;
      if (seen - acc != 4) begin
        bad++;
        $display("FAIL random_latency angle=%h got %0d want 4", a, seen - acc);
      end
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    bus.out_ready = 1'b1;
    issue(16'h1000, 1'b0, acc);
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, rom_addr, bus.sin_out, bus.cos_out} !== 38'h0) begin
      bad++;
      $display("FAIL mid_reset got r=%b v=%b addr=%h sin=%h cos=%h want all 0",
               bus.in_ready, bus.out_valid, rom_addr, bus.sin_out, bus.cos_out);
    end
    sb_q.delete();
    @(negedge sys_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      total++;
      if (bus.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_no_result cycle=%0d out_valid got %b want 0", i, bus.out_valid);
      end
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_ready got %b want 1", bus.in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mirror();
    test_sign_wrap();
    test_backpressure();
    test_back_to_back();
    test_random();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d want 0", sb_q.size());
    end
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
